// File: rtl/riscv_pkg.sv
// Shared RV32 constants for fetch and control: datapath width, canonical NOP, major opcodes.
// Pure definitions, no latency or backpressure.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011,
        OP_SYSTEM = 7'b1110011
    } opcode_e;

    function automatic opcode_e opcode_of(input logic [31:0] instr);
        return opcode_e'(instr[6:0]);
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch (master) and imem (slave).
// Request held until a response is accepted; rvalid qualifies rdata for the current address.
interface fetch_stage_if;
    import riscv_pkg::*;

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: 1-cycle load of a fetched word; flush inserts a NOP bubble.
// Stall holds every field; an empty fetch slot also becomes a bubble with pc fields retained.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            stall_i,
    input  logic            fetch_vld_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_plus4_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            valid_o
);

    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        // Flush outranks stall; pc fields always keep their last value on a bubble.
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (stall_i) begin
            valid_d = valid_q;
        end else if (fetch_vld_i) begin
            instr_d    = instr_i;
            pc_d       = pc_i;
            pc_plus4_d = pc_plus4_i;
            valid_d    = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_plus4_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch: PC register driving imem, result registered into IF/ID; 1 cycle response-to-valid, 1 instr/cycle.
// Address held across wait states and stalls; redirect beats flush beats stall.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned XLEN     = riscv_pkg::XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              redirect_i,
    input  logic [XLEN-1:0]   redirect_pc_i,
    fetch_stage_if.master     imem,
    output logic [XLEN-1:0]   instr_o,
    output logic [XLEN-1:0]   pc_o,
    output logic [XLEN-1:0]   pc_plus4_o,
    output logic              valid_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus4;
    logic            accept;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign accept   = imem.imem_rvalid_i & ~stall_i & ~flush_i & ~redirect_i;

    always_comb begin
        pc_d = pc_q;
        // Targets are forced word-aligned; the low bits of the request are ignored.
        if (redirect_i) begin
            pc_d = redirect_pc_i & ~XLEN'(3);
        end else if (accept) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign imem.imem_req_o  = ~rst;
    assign imem.imem_addr_o = pc_q;

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_i | flush_i),
        .stall_i     (stall_i),
        .fetch_vld_i (imem.imem_rvalid_i),
        .instr_i     (imem.imem_rdata_i),
        .pc_i        (pc_q),
        .pc_plus4_i  (pc_plus4),
        .instr_o     (instr_o),
        .pc_o        (pc_o),
        .pc_plus4_o  (pc_plus4_o),
        .valid_o     (valid_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, stall, redirect, wait states, wrap, flush, mid-run reset.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic        rvalid;

    int compared   = 0;
    int mismatched = 0;

    fetch_stage_if imem_bus ();

    fetch_stage #(.RESET_PC(32'h0000_0100), .XLEN(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem          (imem_bus.master),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .pc_plus4_o    (pc_plus4_o),
        .valid_o       (valid_o)
    );

    always #5 clk = ~clk;

    // Memory model: each word is a fixed scramble of its address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    assign imem_bus.imem_rvalid_i = rvalid;
    assign imem_bus.imem_rdata_i  = mem_word(imem_bus.imem_addr_o);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_if(input string tag, input logic [31:0] e_addr, input logic e_vld,
                            input logic [31:0] e_instr, input logic [31:0] e_pc,
                            input logic [31:0] e_pc4);
        check({tag, ".addr"},  imem_bus.imem_addr_o, e_addr);
        check({tag, ".valid"}, {31'd0, valid_o}, {31'd0, e_vld});
        check({tag, ".instr"}, instr_o, e_instr);
        check({tag, ".pc"},    pc_o, e_pc);
        check({tag, ".pc4"},   pc_plus4_o, e_pc4);
    endtask

    initial begin
        rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0; redirect_i = 1'b0;
        redirect_pc_i = 32'h0; rvalid = 1'b1;

        step(); step(); step();
        check("rst_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
        check_if("rst", 32'h100, 1'b0, NOP, 32'h0, 32'h0);

        rst = 1'b0;
        #1;
        check("req_after_rst", {31'd0, imem_bus.imem_req_o}, 32'd1);
        check("first_addr", imem_bus.imem_addr_o, 32'h100);
        step();
        check_if("acc100", 32'h104, 1'b1, mem_word(32'h100), 32'h100, 32'h104);
        step();
        check_if("acc104", 32'h108, 1'b1, mem_word(32'h104), 32'h104, 32'h108);

        stall_i = 1'b1;
        step();
        check_if("stall1", 32'h108, 1'b1, mem_word(32'h104), 32'h104, 32'h108);
        step();
        check_if("stall2", 32'h108, 1'b1, mem_word(32'h104), 32'h104, 32'h108);
        stall_i = 1'b0;
        step();
        check_if("resume", 32'h10C, 1'b1, mem_word(32'h108), 32'h108, 32'h10C);

        // Flush together with stall: flush wins, PC held.
        flush_i = 1'b1; stall_i = 1'b1;
        step();
        check_if("flush_stall", 32'h10C, 1'b0, NOP, 32'h108, 32'h10C);
        flush_i = 1'b0; stall_i = 1'b0;

        redirect_i = 1'b1; redirect_pc_i = 32'h203; stall_i = 1'b1;
        step();
        check_if("redir_stall", 32'h200, 1'b0, NOP, 32'h108, 32'h10C);
        redirect_i = 1'b0; stall_i = 1'b0; rvalid = 1'b0;

        step();
        check_if("wait1", 32'h200, 1'b0, NOP, 32'h108, 32'h10C);
        step();
        check_if("wait2", 32'h200, 1'b0, NOP, 32'h108, 32'h10C);
        step();
        check_if("wait3", 32'h200, 1'b0, NOP, 32'h108, 32'h10C);
        rvalid = 1'b1;
        step();
        check_if("acc200", 32'h204, 1'b1, mem_word(32'h200), 32'h200, 32'h204);

        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        step();
        check_if("redir_top", 32'hFFFF_FFFC, 1'b0, NOP, 32'h200, 32'h204);
        redirect_i = 1'b0;
        step();
        check_if("wrap", 32'h0, 1'b1, mem_word(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0);

        redirect_i = 1'b1; redirect_pc_i = 32'h10;
        step();
        check_if("redir10", 32'h10, 1'b0, NOP, 32'hFFFF_FFFC, 32'h0);
        redirect_i = 1'b0; flush_i = 1'b1;
        step();
        check_if("flush_acc", 32'h10, 1'b0, NOP, 32'hFFFF_FFFC, 32'h0);
        flush_i = 1'b0;
        step();
        check_if("refetch10", 32'h14, 1'b1, mem_word(32'h10), 32'h10, 32'h14);

        // Reset mid-stream discards the pending fetch at 0x14.
        rst = 1'b1;
        step();
        check("mid_rst_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
        check_if("mid_rst", 32'h100, 1'b0, NOP, 32'h0, 32'h0);
        rst = 1'b0;
        #1;
        check("mid_rst_addr", imem_bus.imem_addr_o, 32'h100);
        step();
        check_if("post_rst", 32'h104, 1'b1, mem_word(32'h100), 32'h100, 32'h104);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC fetched first after reset.
REQ-002 SHALL have parameter XLEN, default 32, the address and data width; only 32 is supported.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port stall_i  in  1  hold PC and IF/ID (load-use hazard).
REQ-006 SHALL have port flush_i  in  1  squash IF/ID contents to a bubble.
REQ-007 SHALL have port redirect_i  in  1  taken branch/jump; load redirect_pc_i.
REQ-008 SHALL have port redirect_pc_i  in  32  redirect target.
REQ-009 SHALL have port imem_req_o  out  1  fetch request active.
REQ-010 SHALL have port imem_addr_o  out  32  fetch address; equals internal pc_q.
REQ-011 SHALL have port imem_rvalid_i  in  1  imem_rdata_i valid for the current imem_addr_o.
REQ-012 SHALL have port imem_rdata_i  in  32  fetched instruction word.
REQ-013 SHALL have port instr_o  out  32  IF/ID instruction to decode/control.
REQ-014 SHALL have port pc_o  out  32  IF/ID PC of instr_o.
REQ-015 SHALL have port pc_plus4_o  out  32  IF/ID pc_o+4 (link value for JAL/JALR).
REQ-016 SHALL have port valid_o  out  1  IF/ID holds a real instruction.

Function
REQ-017 SHALL drive imem_req_o=1 in every cycle that rst=0, and hold imem_addr_o stable until accepted or redirected.
REQ-018 SHALL define accept as imem_rvalid_i=1 & stall_i=0 & flush_i=0 & redirect_i=0.
REQ-019 On accept: instr_o<=imem_rdata_i, pc_o<=pc_q, pc_plus4_o<=pc_q+4, valid_o<=1, pc_q<=pc_q+4.
REQ-020 SHALL apply priority, per cycle: rst > redirect_i > flush_i > stall_i > normal.
REQ-021 redirect_i=1: pc_q<={redirect_pc_i[31:2],2'b00}; valid_o<=0; instr_o<=NOP; any imem response this cycle discarded.
REQ-022 flush_i=1 (no redirect): valid_o<=0, instr_o<=NOP, pc_q held; the response is discarded and re-fetched.
REQ-023 stall_i=1 (no redirect/flush): instr_o, pc_o, pc_plus4_o, valid_o and pc_q all held; the response is discarded.
REQ-024 Normal with imem_rvalid_i=0: valid_o<=0, instr_o<=NOP, pc_q held (wait-state bubble).
REQ-025 NOP SHALL be 32'h0000_0013 (addi x0,x0,0); pc_o/pc_plus4_o keep their last values on bubbles.
REQ-026 PC arithmetic SHALL be modulo 2^32: pc_q=32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-027 Best-case latency SHALL be 1 cycle from a response to valid_o; throughput is 1 instr/cycle with imem_rvalid_i held high.
REQ-028 SHALL be a redirect, not a stall hold, when redirect_i and stall_i are both high.

Reset
REQ-029 While rst=1: pc_q<=RESET_PC, imem_req_o=0, valid_o<=0, instr_o<=NOP, pc_o<=0, pc_plus4_o<=0.
REQ-030 SHALL drop any in-flight fetch on reset mid-operation; the first request after rst falls is RESET_PC.

Structure
REQ-031 SHALL take XLEN, the NOP encoding and the RISC-V opcode constants from shared package riscv_pkg, used also by the control unit.
REQ-032 SHALL place the IF/ID register (instr, pc, pc_plus4, valid; stall/flush) in sub-module if_id_reg; PC logic stays in fetch_stage.

Verification
REQ-033 Reset: RESET_PC=32'h100, rst 3 cycles, rvalid=1 -> imem_addr_o 0x100,0x104,0x108; pc_o 0x100 one cycle after first request; pc_plus4_o 0x104.
REQ-034 Stall: stall_i high 2 cycles at pc_q=0x108 -> outputs frozen at pc_o 0x104, imem_addr_o stays 0x108; resumes with pc_o 0x108.
REQ-035 Redirect: redirect_i=1, redirect_pc_i=32'h203 with stall_i=1 -> next imem_addr_o 0x200, valid_o=0, instr_o=0x00000013.
REQ-036 Wait states: imem_rvalid_i low 3 cycles -> 3 bubbles (valid_o=0), imem_addr_o constant, no PC skip.
REQ-037 Wrap: redirect to 0xFFFFFFFC, then accept -> pc_o 0xFFFFFFFC, pc_plus4_o 0x0, next imem_addr_o 0x0.
REQ-038 Flush during accept: flush_i=1, rvalid=1 at 0x10 -> valid_o=0, and the next cycle re-fetches 0x10.
